// File: rtl/stepper_ramp_ctrl.sv
// stepper_ramp_ctrl: STEP/DIR pulse generator with trapezoidal accel/cruise/decel profile
module stepper_ramp_ctrl #(
    parameter int CNT_W        = 20,
    parameter int STEP_W       = 32,
    parameter int START_PERIOD = 20000,
    parameter int MIN_PERIOD   = 5000,
    parameter int ACCEL_DEC    = 500,
    parameter int PULSE_HIGH   = 2500,
    parameter int DIR_SETUP    = 100
) (
    input  logic              i_Clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_direction,
    input  logic [STEP_W-1:0] i_total_steps,
    input  logic              i_abort,
    output logic              o_step_control,
    output logic              o_direction,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [STEP_W-1:0] o_steps_done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [CNT_W:0]    START_X = (CNT_W+1)'(START_PERIOD);
    localparam logic [CNT_W:0]    MIN_X   = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]    ACC_X   = (CNT_W+1)'(ACCEL_DEC);
    localparam logic [CNT_W-1:0]  PH_LAST = CNT_W'(PULSE_HIGH - 1);
    localparam logic [CNT_W-1:0]  PH_P1   = CNT_W'(PULSE_HIGH + 1);
    localparam logic [CNT_W-1:0]  DS      = CNT_W'(DIR_SETUP);
    localparam logic [CNT_W-1:0]  C1      = CNT_W'(1);
    localparam logic [STEP_W-1:0] S1      = STEP_W'(1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt, period;
    logic [STEP_W-1:0] ramp_cnt, total;
    logic              abort_pend;
    logic [CNT_W:0]    p_up, p_dn;
    logic [CNT_W-1:0]  p_inc, p_dec, low_last;
    logic [STEP_W-1:0] k_next, remaining;

    // saturating period update candidates and end-of-step bookkeeping
    always_comb begin
        p_up      = {1'b0, period} + ACC_X;
        p_dn      = {1'b0, period} - ACC_X;
        p_inc     = (p_up > START_X) ? START_X[CNT_W-1:0] : p_up[CNT_W-1:0];
        p_dec     = (p_dn[CNT_W] || p_dn < MIN_X) ? MIN_X[CNT_W-1:0] : p_dn[CNT_W-1:0];
        low_last  = period - PH_P1;
        k_next    = o_steps_done + S1;
        remaining = total - k_next;
    end

    // move sequencer: setup delay, high/low phases, ramp profile, abort and completion
    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            period         <= START_X[CNT_W-1:0];
            ramp_cnt       <= '0;
            total          <= '0;
            abort_pend     <= 1'b0;
            o_step_control <= 1'b0;
            o_direction    <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_aborted      <= 1'b0;
            o_steps_done   <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: if (i_start && !i_abort) begin
                    o_direction  <= i_direction;
                    total        <= i_total_steps;
                    o_steps_done <= '0;
                    o_aborted    <= 1'b0;
                    o_busy       <= 1'b1;
                    cnt          <= '0;
                    abort_pend   <= 1'b0;
                    state        <= (i_total_steps == '0) ? S_DONE : S_SETUP;
                end
                S_SETUP: if (i_abort) begin
                    state     <= S_DONE;
                    o_aborted <= 1'b1;
                end else if (cnt == DS) begin
                    state          <= S_HIGH;
                    o_step_control <= 1'b1;
                    cnt            <= '0;
                end else begin
                    cnt <= cnt + C1;
                end
                S_HIGH: begin
                    if (i_abort)
                        abort_pend <= 1'b1;
                    if (cnt == PH_LAST) begin
                        o_step_control <= 1'b0;
                        cnt            <= '0;
                        if (abort_pend || i_abort) begin
                            state     <= S_DONE;
                            o_aborted <= 1'b1;
                        end else begin
                            state <= S_LOW;
                        end
                    end else begin
                        cnt <= cnt + C1;
                    end
                end
                S_LOW: if (i_abort) begin
                    state     <= S_DONE;
                    o_aborted <= 1'b1;
                end else if (cnt == low_last) begin
                    cnt          <= '0;
                    o_steps_done <= k_next;
                    if (remaining == '0) begin
                        state <= S_DONE;
                    end else begin
                        state          <= S_HIGH;
                        o_step_control <= 1'b1;
                        if (remaining <= ramp_cnt) begin
                            period   <= p_inc;
                            ramp_cnt <= (ramp_cnt == '0) ? '0 : ramp_cnt - S1;
                        end else if (period > MIN_X[CNT_W-1:0]) begin
                            period   <= p_dec;
                            ramp_cnt <= ramp_cnt + S1;
                        end
                    end
                end else begin
                    cnt <= cnt + C1;
                end
                S_DONE: begin
                    o_done     <= 1'b1;
                    o_busy     <= 1'b0;
                    period     <= START_X[CNT_W-1:0];
                    ramp_cnt   <= '0;
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// tb_stepper_ramp_ctrl: directed vector table plus corner-case sequences for stepper_ramp_ctrl
module tb_stepper_ramp_ctrl;
    localparam int STEP_W = 16;

    logic              i_Clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_direction = 1'b0;
    logic              i_abort = 1'b0;
    logic [STEP_W-1:0] i_total_steps = '0;
    logic              o_step_control, o_direction, o_busy, o_done, o_aborted;
    logic [STEP_W-1:0] o_steps_done;

    stepper_ramp_ctrl #(
        .CNT_W(8), .STEP_W(STEP_W), .START_PERIOD(10), .MIN_PERIOD(6),
        .ACCEL_DEC(2), .PULSE_HIGH(3), .DIR_SETUP(2)
    ) dut (
        .i_Clk(i_Clk), .i_rst(i_rst), .i_start(i_start), .i_direction(i_direction),
        .i_total_steps(i_total_steps), .i_abort(i_abort),
        .o_step_control(o_step_control), .o_direction(o_direction), .o_busy(o_busy),
        .o_done(o_done), .o_aborted(o_aborted), .o_steps_done(o_steps_done)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        int   n;
        logic dir;
        int   pulses;
        int   done_rel;
        int   span;
    } vec_t;

    int   total = 0, bad = 0;
    int   cyc = 0, dones = 0, done_at = 0, hcnt = 0;
    int   rise_at[$];
    int   sd_at[$];
    logic prev = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // output monitor: pulse rise times, high widths, done pulses
    always @(negedge i_Clk) begin
        cyc++;
        if (o_step_control && !prev) begin
            rise_at.push_back(cyc);
            sd_at.push_back(int'(o_steps_done));
        end
        if (o_step_control)
            hcnt++;
        else if (prev) begin
            chk("high_len", hcnt, 3);
            hcnt = 0;
        end
        if (o_done) begin
            dones++;
            done_at = cyc;
        end
        prev = o_step_control;
    end

    task automatic start_move(input int n, input logic d, output int acc);
        @(negedge i_Clk);
        i_total_steps = STEP_W'(n);
        i_direction   = d;
        i_start       = 1'b1;
        @(posedge i_Clk);
        #1;
        i_start = 1'b0;
        acc     = cyc;
    endtask

    task automatic wait_done(input int acc, output int rel);
        int d0 = dones;
        rel = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_Clk);
            #1;
            if (dones != d0) begin
                rel = done_at - acc - 1;
                break;
            end
        end
        if (rel < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_rises(input int n);
        int ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_Clk);
            #1;
            if (rise_at.size() >= n) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk("rise_timeout", rise_at.size(), n);
    endtask

    task automatic run_vec(input vec_t t);
        int acc, rel;
        rise_at.delete();
        sd_at.delete();
        start_move(t.n, t.dir, acc);
        chk("dir", o_direction, t.dir);
        chk("busy_on", o_busy, 1);
        wait_done(acc, rel);
        chk("done_rel", rel, t.done_rel);
        chk("pulses", rise_at.size(), t.pulses);
        chk("steps_done", o_steps_done, t.n);
        chk("busy_off", o_busy, 0);
        chk("aborted", o_aborted, 0);
        if (t.pulses > 0) begin
            chk("first_rise", rise_at[0] - acc - 1, 3);
            chk("span", rise_at[rise_at.size()-1] - rise_at[0], t.span);
        end
        @(negedge i_Clk);
        #1;
        chk("done_width", o_done, 0);
    endtask

    initial begin
        vec_t v[6];
        int   acc, rel, d0;
        int   gaps[4] = '{10, 8, 6, 8};
        v[0] = '{5, 1'b1, 5, 46, 32};
        v[1] = '{12, 1'b0, 12, 88, 74};
        v[2] = '{0, 1'b1, 0, 1, 0};
        v[3] = '{1, 1'b0, 1, 14, 0};
        v[4] = '{2, 1'b1, 2, 22, 10};
        v[5] = '{3, 1'b0, 3, 32, 18};

        repeat (3) @(posedge i_Clk);
        #1;
        chk("rst_step", o_step_control, 0);
        chk("rst_dir", o_direction, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_aborted", o_aborted, 0);
        chk("rst_steps", o_steps_done, 0);
        i_rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(v[i]);

        run_vec(v[0]);
        for (int j = 0; j < 4; j++) chk("gap", rise_at[j+1] - rise_at[j], gaps[j]);
        for (int j = 0; j < 5; j++) chk("steps_at_rise", sd_at[j], j);

        rise_at.delete();
        start_move(5, 1'b1, acc);
        wait_rises(3);
        i_abort = 1'b1;
        @(posedge i_Clk);
        #1;
        i_abort = 1'b0;
        wait_done(acc, rel);
        chk("abort_done_rel", rel, 25);
        chk("abort_pulses", rise_at.size(), 3);
        chk("abort_steps", o_steps_done, 2);
        chk("abort_flag", o_aborted, 1);
        chk("abort_busy", o_busy, 0);
        start_move(1, 1'b0, acc);
        chk("aborted_clr", o_aborted, 0);
        wait_done(acc, rel);
        chk("after_abort_rel", rel, 14);

        rise_at.delete();
        start_move(2, 1'b1, acc);
        repeat (4) @(negedge i_Clk);
        i_total_steps = 16'd7;
        i_start = 1'b1;
        @(posedge i_Clk);
        #1;
        i_start = 1'b0;
        wait_done(acc, rel);
        chk("busy_ign_rel", rel, 22);
        chk("busy_ign_pulses", rise_at.size(), 2);
        chk("busy_ign_steps", o_steps_done, 2);
        @(negedge i_Clk);
        i_start = 1'b1;
        i_abort = 1'b1;
        i_total_steps = 16'd4;
        @(posedge i_Clk);
        #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start_abort_busy", o_busy, 0);
        d0 = dones;
        repeat (5) @(negedge i_Clk);
        #1;
        chk("start_abort_nodone", dones, d0);
        chk("start_abort_steps", o_steps_done, 2);

        rise_at.delete();
        start_move(5, 1'b1, acc);
        wait_rises(2);
        repeat (4) @(negedge i_Clk);
        i_rst = 1'b1;
        @(posedge i_Clk);
        #1;
        i_rst = 1'b0;
        chk("mid_rst_step", o_step_control, 0);
        chk("mid_rst_dir", o_direction, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_steps", o_steps_done, 0);
        d0 = dones;
        repeat (20) @(negedge i_Clk);
        #1;
        chk("mid_rst_nodone", dones, d0);
        chk("mid_rst_pulses", rise_at.size(), 2);
        run_vec('{1, 1'b1, 1, 14, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
